// File: rtl/ps2_mouse_pkg.sv
// Shared constants, byte0 field layout and FSM encodings for the PS/2 mouse
// cursor tracker.
package ps2_mouse_pkg;

  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_DISABLE = 8'hF5;
  localparam logic [7:0] ACK         = 8'hFA;

  localparam int B0_BTN_L  = 0;
  localparam int B0_BTN_R  = 1;
  localparam int B0_SYNC   = 3;
  localparam int B0_X_SIGN = 4;
  localparam int B0_Y_SIGN = 5;
  localparam int B0_X_OVF  = 6;
  localparam int B0_Y_OVF  = 7;

  typedef enum logic [1:0] {
    CMD_IDLE,
    CMD_SEND,
    CMD_WAIT_SENT,
    CMD_WAIT_ACK
  } cmd_state_t;

  typedef enum logic [1:0] {
    PKT_B0,
    PKT_B1,
    PKT_B2
  } pkt_state_t;

  typedef struct packed {
    logic y_ovf;
    logic x_ovf;
    logic y_sign;
    logic x_sign;
    logic btn_r;
    logic btn_l;
  } b0_t;

endpackage

// File: rtl/mouse_axis_accumulator.sv
// One cursor axis: saturating pixel integrator with a centred reset value
// and a registered cell index (pixel / CELL).
module mouse_axis_accumulator #(
  parameter int MAX_POS = 319,
  parameter int CENTER  = 160,
  parameter int CELL    = 5,
  parameter int POS_W   = 9,
  parameter int CELL_W  = 6,
  parameter bit NEGATE  = 1'b0
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iUpdate,
  input  logic [8:0]        iDelta,
  output logic [CELL_W-1:0] oCell
);

  localparam logic signed [10:0] MAX_S = 11'(MAX_POS);

  logic [POS_W-1:0]   r_pos;
  logic [CELL_W-1:0]  r_cell;
  logic signed [10:0] w_delta;
  logic signed [10:0] w_sum;
  logic [POS_W-1:0]   w_next;
  logic [CELL_W-1:0]  w_cell;

  always_comb begin
    w_delta = 11'($signed(iDelta));
    if (NEGATE) w_delta = -w_delta;
    w_sum = signed'(11'(r_pos)) + w_delta;
    if (w_sum < 0)
      w_next = '0;
    else if (w_sum > MAX_S)
      w_next = POS_W'(MAX_POS);
    else
      w_next = w_sum[POS_W-1:0];
    w_cell = CELL_W'(w_next / POS_W'(CELL));
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_pos  <= POS_W'(CENTER);
      r_cell <= CELL_W'(CENTER / CELL);
    end else if (iUpdate) begin
      r_pos  <= w_next;
      r_cell <= w_cell;
    end
  end

  assign oCell = r_cell;

endmodule

// File: rtl/mouse_cursor_tracker.sv
// PS/2 mouse packet assembler, cursor integrator and F4/F5 command handshake.
// Define PACKET_TIMEOUT_EN to abort stalled packets and unanswered commands.
module mouse_cursor_tracker
  import ps2_mouse_pkg::*;
#(
  parameter int SCREEN_WIDTH   = 320,
  parameter int SCREEN_HEIGHT  = 240,
  parameter int CELL_DIMENSION = 5,
  parameter int UPPER_BITS     = 6,
  parameter int TIMEOUT_CYCLES = 2_500_000
) (
  input  logic                  iClk,
  input  logic                  iReset,
  input  logic [7:0]            iData,
  input  logic                  iDataValid,
  input  logic                  iStartTransmission,
  input  logic                  iEnableMouse,
  input  logic                  iCommandSent,
  output logic [7:0]            oCommand,
  output logic                  oSendCommand,
  output logic                  oStreaming,
  output logic                  oCmdError,
  output logic [UPPER_BITS-1:0] oX_cell,
  output logic [UPPER_BITS-1:0] oY_cell,
  output logic                  oBtnL,
  output logic                  oBtnR,
  output logic                  oPacketValid
);

  localparam int MAX_DIM =
    (SCREEN_WIDTH > SCREEN_HEIGHT) ? SCREEN_WIDTH : SCREEN_HEIGHT;
  localparam int POS_W = $clog2(MAX_DIM);

  cmd_state_t r_cmd;
  pkt_state_t r_pkt;
  b0_t        r_b0;
  logic [7:0] r_b1;
  logic       r_en;
  logic [7:0] r_command;
  logic       r_send;
  logic       r_stream;
  logic       r_err;
  logic       r_btn_l;
  logic       r_btn_r;
  logic       r_pkt_valid;
  logic       w_timeout;
  logic       w_pkt_run;
  logic       w_pkt_done;
  logic [8:0] w_dx;
  logic [8:0] w_dy;

`ifdef PACKET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          w_waiting;

  assign w_waiting = (r_pkt != PKT_B0) ||
                     (r_cmd == CMD_WAIT_SENT) ||
                     (r_cmd == CMD_WAIT_ACK);
  assign w_timeout = w_waiting &&
                     (r_tmo_cnt == TW'(TIMEOUT_CYCLES));

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset)
      r_tmo_cnt <= '0;
    else if (!w_waiting || iDataValid || w_timeout)
      r_tmo_cnt <= '0;
    else
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
  end
`else
  // A negative budget would be meaningless, so this is constant false.
  assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_cmd     <= CMD_IDLE;
      r_en      <= 1'b0;
      r_command <= 8'h00;
      r_send    <= 1'b0;
      r_stream  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_send <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_cmd)
        CMD_IDLE: begin
          if (iStartTransmission) begin
            r_en      <= iEnableMouse;
            r_command <= iEnableMouse ? CMD_ENABLE : CMD_DISABLE;
            r_send    <= 1'b1;
            r_cmd     <= CMD_SEND;
          end
        end
        CMD_SEND: r_cmd <= CMD_WAIT_SENT;
        CMD_WAIT_SENT: begin
          if (w_timeout) begin
            r_err <= 1'b1;
            r_cmd <= CMD_IDLE;
          end else if (iCommandSent) begin
            r_cmd <= CMD_WAIT_ACK;
          end
        end
        CMD_WAIT_ACK: begin
          if (w_timeout) begin
            r_err <= 1'b1;
            r_cmd <= CMD_IDLE;
          end else if (iDataValid) begin
            if (iData == ACK) r_stream <= r_en;
            else              r_err    <= 1'b1;
            r_cmd <= CMD_IDLE;
          end
        end
        default: r_cmd <= CMD_IDLE;
      endcase
    end
  end

  // A same-cycle command request steals the byte and aborts the packet.
  assign w_pkt_run  = r_stream && (r_cmd == CMD_IDLE) &&
                      !iStartTransmission;
  assign w_pkt_done = w_pkt_run && !w_timeout && iDataValid &&
                      (r_pkt == PKT_B2);

  assign w_dx = r_b0.x_ovf ? 9'd0 : {r_b0.x_sign, r_b1};
  assign w_dy = r_b0.y_ovf ? 9'd0 : {r_b0.y_sign, iData};

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_pkt       <= PKT_B0;
      r_b0        <= '0;
      r_b1        <= 8'h00;
      r_btn_l     <= 1'b0;
      r_btn_r     <= 1'b0;
      r_pkt_valid <= 1'b0;
    end else begin
      r_pkt_valid <= 1'b0;
      if (!w_pkt_run || w_timeout) begin
        r_pkt <= PKT_B0;
      end else if (iDataValid) begin
        unique case (r_pkt)
          PKT_B0: begin
            if (iData[B0_SYNC]) begin
              r_b0 <= '{y_ovf:  iData[B0_Y_OVF],
                        x_ovf:  iData[B0_X_OVF],
                        y_sign: iData[B0_Y_SIGN],
                        x_sign: iData[B0_X_SIGN],
                        btn_r:  iData[B0_BTN_R],
                        btn_l:  iData[B0_BTN_L]};
              r_pkt <= PKT_B1;
            end
          end
          PKT_B1: begin
            r_b1  <= iData;
            r_pkt <= PKT_B2;
          end
          PKT_B2: begin
            r_btn_l     <= r_b0.btn_l;
            r_btn_r     <= r_b0.btn_r;
            r_pkt_valid <= 1'b1;
            r_pkt       <= PKT_B0;
          end
          default: r_pkt <= PKT_B0;
        endcase
      end
    end
  end

  mouse_axis_accumulator #(
    .MAX_POS(SCREEN_WIDTH - 1),
    .CENTER (SCREEN_WIDTH / 2),
    .CELL   (CELL_DIMENSION),
    .POS_W  (POS_W),
    .CELL_W (UPPER_BITS),
    .NEGATE (1'b0)
  ) u_x (
    .iClk   (iClk),
    .iReset (iReset),
    .iUpdate(w_pkt_done),
    .iDelta (w_dx),
    .oCell  (oX_cell)
  );

  mouse_axis_accumulator #(
    .MAX_POS(SCREEN_HEIGHT - 1),
    .CENTER (SCREEN_HEIGHT / 2),
    .CELL   (CELL_DIMENSION),
    .POS_W  (POS_W),
    .CELL_W (UPPER_BITS),
    .NEGATE (1'b1)
  ) u_y (
    .iClk   (iClk),
    .iReset (iReset),
    .iUpdate(w_pkt_done),
    .iDelta (w_dy),
    .oCell  (oY_cell)
  );

  assign oCommand     = r_command;
  assign oSendCommand = r_send;
  assign oStreaming   = r_stream;
  assign oCmdError    = r_err;
  assign oBtnL        = r_btn_l;
  assign oBtnR        = r_btn_r;
  assign oPacketValid = r_pkt_valid;

endmodule

// File: tb/tb_mouse_cursor_tracker.sv
// Directed bench for mouse_cursor_tracker: packet table plus hand-written
// command, abort, clamp, timeout and reset sequences.
module tb_mouse_cursor_tracker;

`ifdef PACKET_TIMEOUT_EN
  localparam int TMO = 200;
`else
  localparam int TMO = 2_500_000;
`endif

  logic       iClk = 1'b0;
  logic       iReset = 1'b1;
  logic [7:0] iData = 8'h00;
  logic       iDataValid = 1'b0;
  logic       iStartTransmission = 1'b0;
  logic       iEnableMouse = 1'b0;
  logic       iCommandSent = 1'b0;
  logic [7:0] oCommand;
  logic       oSendCommand;
  logic       oStreaming;
  logic       oCmdError;
  logic [5:0] oX_cell;
  logic [5:0] oY_cell;
  logic       oBtnL;
  logic       oBtnR;
  logic       oPacketValid;

  int n_chk = 0;
  int n_pass = 0;

  mouse_cursor_tracker #(.TIMEOUT_CYCLES(TMO)) dut (
    .iClk              (iClk),
    .iReset            (iReset),
    .iData             (iData),
    .iDataValid        (iDataValid),
    .iStartTransmission(iStartTransmission),
    .iEnableMouse      (iEnableMouse),
    .iCommandSent      (iCommandSent),
    .oCommand          (oCommand),
    .oSendCommand      (oSendCommand),
    .oStreaming        (oStreaming),
    .oCmdError         (oCmdError),
    .oX_cell           (oX_cell),
    .oY_cell           (oY_cell),
    .oBtnL             (oBtnL),
    .oBtnR             (oBtnR),
    .oPacketValid      (oPacketValid)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    int         xc;
    int         yc;
    logic       l;
    logic       r;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    iData      = b;
    iDataValid = 1'b1;
    tick();
    iDataValid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
  endtask

  task automatic do_cmd(input logic en, input logic [7:0] reply,
                        input logic with_byte);
    iStartTransmission = 1'b1;
    iEnableMouse       = en;
    iData              = 8'h08;
    iDataValid         = with_byte;
    tick();
    iStartTransmission = 1'b0;
    iDataValid         = 1'b0;
    check("send_pulse", oSendCommand, 1);
    check("command", oCommand, en ? 8'hF4 : 8'hF5);
    tick();
    check("send_one_cycle", oSendCommand, 0);
    tick();
    iCommandSent = 1'b1;
    tick();
    iCommandSent = 1'b0;
    send_byte(reply);
  endtask

  initial begin
    vecs[0] = '{8'h08, 8'h05, 8'h00, 33, 24, 1'b0, 1'b0};
    vecs[1] = '{8'h09, 8'h00, 8'h0A, 33, 22, 1'b1, 1'b0};
    vecs[2] = '{8'h2A, 8'h00, 8'hF6, 33, 24, 1'b0, 1'b1};
    vecs[3] = '{8'h18, 8'hFB, 8'h00, 32, 24, 1'b0, 1'b0};
    vecs[4] = '{8'h38, 8'hFF, 8'hFF, 31, 24, 1'b0, 1'b0};
    vecs[5] = '{8'h08, 8'hFF, 8'h00, 63, 24, 1'b0, 1'b0};
    vecs[6] = '{8'h28, 8'h00, 8'h80, 63, 47, 1'b0, 1'b0};
    vecs[7] = '{8'h48, 8'hFF, 8'h00, 63, 47, 1'b0, 1'b0};
    vecs[8] = '{8'h89, 8'h00, 8'h7F, 63, 47, 1'b1, 1'b0};
    vecs[9] = '{8'h08, 8'h00, 8'hFF, 63, 0,  1'b0, 1'b0};

    tick();
    tick();
    check("rst_xcell", oX_cell, 32);
    check("rst_ycell", oY_cell, 24);
    check("rst_btnl", oBtnL, 0);
    check("rst_btnr", oBtnR, 0);
    check("rst_stream", oStreaming, 0);
    check("rst_send", oSendCommand, 0);
    check("rst_command", oCommand, 0);
    check("rst_pktvalid", oPacketValid, 0);
    check("rst_cmderr", oCmdError, 0);
    iReset = 1'b0;
    tick();

    send_pkt(8'h08, 8'h05, 8'h00);
    check("idle_pktvalid", oPacketValid, 0);
    check("idle_xcell", oX_cell, 32);

    do_cmd(1'b1, 8'hFA, 1'b0);
    check("enable_stream", oStreaming, 1);
    check("enable_noerr", oCmdError, 0);

    send_byte(8'h00);
    check("nosync_pktvalid", oPacketValid, 0);

    for (int i = 0; i < 10; i++) begin
      send_pkt(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      check($sformatf("v%0d_pktvalid", i), oPacketValid, 1);
      check($sformatf("v%0d_xcell", i), oX_cell, vecs[i].xc);
      check($sformatf("v%0d_ycell", i), oY_cell, vecs[i].yc);
      check($sformatf("v%0d_btnl", i), oBtnL, vecs[i].l);
      check($sformatf("v%0d_btnr", i), oBtnR, vecs[i].r);
      tick();
      check($sformatf("v%0d_pulse", i), oPacketValid, 0);
    end

    for (int i = 0; i < 10; i++) begin
      send_pkt(8'h18, 8'h00, 8'h00);
      if (i == 0) check("left1_xcell", oX_cell, 12);
    end
    check("left_clamp_xcell", oX_cell, 0);
    check("left_clamp_ycell", oY_cell, 0);

    do_cmd(1'b0, 8'hAA, 1'b0);
    check("nack_err", oCmdError, 1);
    check("nack_stream", oStreaming, 1);
    tick();
    check("nack_err_pulse", oCmdError, 0);

    do_cmd(1'b0, 8'hFA, 1'b0);
    check("disable_stream", oStreaming, 0);
    send_pkt(8'h08, 8'h05, 8'h00);
    check("disabled_pktvalid", oPacketValid, 0);
    check("disabled_xcell", oX_cell, 0);

    do_cmd(1'b1, 8'hFA, 1'b0);
    check("reenable_stream", oStreaming, 1);

    send_byte(8'h08);
    send_byte(8'h05);
    do_cmd(1'b1, 8'hFA, 1'b0);
    send_pkt(8'h08, 8'h0A, 8'h00);
    check("abort_pktvalid", oPacketValid, 1);
    check("abort_xcell", oX_cell, 2);

    do_cmd(1'b1, 8'hFA, 1'b1);
    send_pkt(8'h08, 8'h0A, 8'h00);
    check("collide_xcell", oX_cell, 4);

`ifdef PACKET_TIMEOUT_EN
    send_byte(8'h08);
    send_byte(8'h05);
    repeat (TMO + 10) tick();
    send_pkt(8'h08, 8'h01, 8'h00);
    check("timeout_pktvalid", oPacketValid, 1);
    check("timeout_xcell", oX_cell, 4);
`endif

    send_byte(8'h09);
    send_byte(8'h05);
    #2;
    iReset = 1'b1;
    #1;
    check("midrst_xcell", oX_cell, 32);
    check("midrst_ycell", oY_cell, 24);
    check("midrst_btnl", oBtnL, 0);
    check("midrst_stream", oStreaming, 0);
    @(negedge iClk);
    iReset = 1'b0;
    tick();
    send_pkt(8'h08, 8'h05, 8'h00);
    check("postrst_pktvalid", oPacketValid, 0);
    check("postrst_xcell", oX_cell, 32);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
